// File: rtl/digit_scan_controller.sv
// ---------------------------------------------------------------------------
// digit_scan_controller : N-digit display scanner with dwell, guard, blanking.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module digit_scan_controller #(
  parameter int N_DIGITS   = 4,
  parameter int SEL_W      = $clog2(N_DIGITS),
  parameter int PRESCALE   = 100000,
  parameter int GUARD      = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [N_DIGITS-1:0] blank_mask,
  output logic [SEL_W-1:0]    sel,
  output logic [N_DIGITS-1:0] an,
  output logic                digit_tick,
  output logic                frame_tick
);

  localparam int CNT_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int SUM_W   = SEL_W + 1;
  localparam int MASK_W  = 2 ** SEL_W;
  localparam logic [N_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  generate
    if (N_DIGITS < 2 || N_DIGITS > 16 || PRESCALE < 2 || GUARD < 0 ||
        GUARD >= PRESCALE || SEL_W < $clog2(N_DIGITS)) begin : g_param_check
      $error("digit_scan_controller: illegal parameter combination");
    end
  endgenerate

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                digit_tick_q, digit_tick_d;
  logic                frame_tick_q, frame_tick_d;

  logic                tc;
  logic                in_guard;
  logic                any_unblanked;
  logic [MASK_W-1:0]   mask_ext;
  logic [SEL_W-1:0]    next_sel;
  logic [SUM_W-1:0]    cand;

  // Mask padded to the full index range so out-of-range sel values stay legal.
  assign mask_ext      = MASK_W'(blank_mask);
  assign tc            = (cnt_q == CNT_W'(PRESCALE - 1));
  assign any_unblanked = ~&blank_mask;

  generate
    if (GUARD > 0) begin : g_guard
      assign in_guard = (cnt_q < CNT_W'(GUARD));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  // Walk k from N_DIGITS down to 1 so the smallest unblanked offset wins.
  always_comb begin
    next_sel = sel_q;
    cand     = '0;
    for (int k = N_DIGITS; k >= 1; k--) begin
      cand = SUM_W'(sel_q) + SUM_W'(k);
      if (cand >= SUM_W'(N_DIGITS)) begin
        cand = cand - SUM_W'(N_DIGITS);
      end
      if (!mask_ext[cand[SEL_W-1:0]]) begin
        next_sel = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    digit_tick_d = 1'b0;
    frame_tick_d = 1'b0;
    an_d         = AN_OFF;

    if (en) begin
      if (tc) begin
        cnt_d        = '0;
        digit_tick_d = 1'b1;
        if (any_unblanked) begin
          sel_d        = next_sel;
          frame_tick_d = (next_sel <= sel_q);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Anode is computed from pre-edge state, so it trails sel by one cycle.
    if (en && !in_guard && !mask_ext[sel_q]) begin
      an_d = (N_DIGITS'(1) << sel_q) ^ AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      an_q         <= AN_OFF;
      digit_tick_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      digit_tick_q <= digit_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign an         = an_q;
  assign digit_tick = digit_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_digit_scan_controller : directed + random checks of two scanner configs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_digit_scan_controller;

  localparam int PRESCALE = 8;
  localparam int GUARD    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] mask4 = '0;
  logic [2:0] mask3 = '0;

  logic [1:0] sel4, sel3;
  logic [3:0] an4;
  logic [2:0] an3;
  logic       dt4, ft4, dt3, ft3;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state per instance: 0 = 4 digits active-low, 1 = 3 digits active-high.
  int m_cnt[2], m_sel[2], m_an[2], m_dt[2], m_ft[2];

  always #5 clk = ~clk;

  digit_scan_controller #(
    .N_DIGITS(4), .SEL_W(2), .PRESCALE(PRESCALE), .GUARD(GUARD), .ACTIVE_LOW(1)
  ) u_dut4 (
    .clk(clk), .reset(rst), .en(en), .blank_mask(mask4),
    .sel(sel4), .an(an4), .digit_tick(dt4), .frame_tick(ft4)
  );

  digit_scan_controller #(
    .N_DIGITS(3), .SEL_W(2), .PRESCALE(PRESCALE), .GUARD(GUARD), .ACTIVE_LOW(0)
  ) u_dut3 (
    .clk(clk), .reset(rst), .en(en), .blank_mask(mask3),
    .sel(sel3), .an(an3), .digit_tick(dt3), .frame_tick(ft3)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input int i, input bit r, input bit e, input logic [15:0] m);
    int n, off, k, ns;
    n   = (i == 0) ? 4 : 3;
    off = (i == 0) ? (1 << n) - 1 : 0;
    if (r) begin
      m_cnt[i] = 0; m_sel[i] = 0; m_an[i] = off; m_dt[i] = 0; m_ft[i] = 0;
      return;
    end
    m_an[i] = (!e || m_cnt[i] < GUARD || m[m_sel[i]]) ? off : ((1 << m_sel[i]) ^ off);
    m_dt[i] = 0;
    m_ft[i] = 0;
    if (e) begin
      if (m_cnt[i] == PRESCALE - 1) begin
        m_cnt[i] = 0;
        m_dt[i]  = 1;
        for (k = 1; k <= n; k++) if (!m[(m_sel[i] + k) % n]) break;
        if (k <= n) begin
          ns = (m_sel[i] + k) % n;
          m_ft[i]  = (ns <= m_sel[i]) ? 1 : 0;
          m_sel[i] = ns;
        end
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst, en, {12'b0, mask4});
    model_step(1, rst, en, {13'b0, mask3});
    #1;
    check("sel4", sel4, m_sel[0]);
    check("an4",  an4,  m_an[0]);
    check("dt4",  dt4,  m_dt[0]);
    check("ft4",  ft4,  m_ft[0]);
    check("sel3", sel3, m_sel[1]);
    check("an3",  an3,  m_an[1]);
    check("dt3",  dt3,  m_dt[1]);
    check("ft3",  ft3,  m_ft[1]);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) tick();
  endtask

  initial begin
    int frames;
    int guard_cnt;

    // Reset held three cycles.
    rst = 1'b1; en = 1'b1; mask4 = 4'b0000; mask3 = 3'b000;
    run(3);
    check("reset_sel4", sel4, 0);
    check("reset_an4",  an4,  4'b1111);
    check("reset_an3",  an3,  3'b000);
    check("reset_ticks", {dt4, ft4, dt3, ft3}, 4'b0000);

    // Basic scan: first advance lands 8 edges after release.
    rst = 1'b0;
    run(2);
    check("guard_an4", an4, 4'b1111);
    tick();
    check("first_an4", an4, 4'b1110);
    run(5);
    check("first_step_sel4", sel4, 1);
    check("first_step_dt4",  dt4,  1);
    frames = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (ft4) frames++;
    end
    check("frames_per_32", frames, 1);

    // Skip pattern, then degenerate masks.
    mask4 = 4'b0101; mask3 = 3'b010;
    run(48);
    check("skip_an4_digits02_off", an4 & 4'b0101, 4'b0101);
    mask4 = 4'b1111; mask3 = 3'b111;
    run(24);
    check("allblank_an4", an4, 4'b1111);
    check("allblank_an3", an3, 3'b000);
    mask4 = 4'b1011; mask3 = 3'b101;
    run(24);
    check("single_sel4", sel4, 2);
    check("single_sel3", sel3, 1);

    // Enable gating at cnt = 5.
    mask4 = 4'b0000; mask3 = 3'b000;
    guard_cnt = 0;
    while (m_cnt[0] != 5 && guard_cnt < 64) begin tick(); guard_cnt++; end
    check("reach_cnt5", m_cnt[0], 5);
    en = 1'b0;
    tick();
    check("en_off_an4", an4, 4'b1111);
    run(9);
    en = 1'b1;
    run(2);
    check("resume_no_tc_yet", dt4, 0);
    tick();
    check("resume_tc", dt4, 1);

    // Reset mid-slot at sel = 2, cnt = 6.
    guard_cnt = 0;
    while (!(m_sel[0] == 2 && m_cnt[0] == 6) && guard_cnt < 128) begin tick(); guard_cnt++; end
    check("reach_sel2_cnt6", (m_sel[0] == 2 && m_cnt[0] == 6) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    check("midreset_sel4", sel4, 0);
    check("midreset_an4",  an4,  4'b1111);
    check("midreset_dt4",  dt4,  0);
    rst = 1'b0;
    tick();
    check("midreset_no_pending_dt4", dt4, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        mask4 = 4'($urandom);
        mask3 = 3'($urandom);
      end
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
